// File: rtl/line_buffer_pkg.sv
// rtl/line_buffer_pkg.sv - shared types and default parameters for line_buffer_n
// Contents:
//   state_t       frame-control FSM encoding (IDLE, FILL, RUN, DROP)
//   DEF_*         default values for the line buffer parameters
package line_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ROWS     = 7;
  localparam int DEF_MAX_COLS = 512;

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - one image row of storage: synchronous write, combinational read
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   addr   in   column address, shared by read and write
//   wdata  in   pixel to store
//   rdata  out  pixel currently stored at addr (value before any write this edge)
module line_ram
  import line_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_MAX_COLS,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/line_buffer_n.sv
// rtl/line_buffer_n.sv - ROWS-tall line buffer emitting one pixel column per accepted beat
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   IMG_SIZE_I         square image side, sampled on the first beat of a frame
//   s_axis_t*          pixel input stream (tdata/tvalid/tready)
//   m_axis_t*          column output stream; slice 0 = oldest row, slice ROWS-1 = current pixel
//   m_axis_tuser       first emitted beat of a frame
//   m_axis_tlast       beat belongs to the last column of its row
//   frame_done_o       one-cycle pulse after the final pixel of a frame
//   size_err_o         sticky flag: a frame started with an unusable size
// Build option: LINE_BUFFER_ZERO_PAD_EN emits during the fill rows too, with
//   not-yet-written rows forced to zero.
module line_buffer_n
  import line_buffer_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ROWS     = DEF_ROWS,
  parameter int MAX_COLS = DEF_MAX_COLS,
  parameter int COL_W    = $clog2(MAX_COLS) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COL_W-1:0]       IMG_SIZE_I,
  input  logic [DATA_W-1:0]      s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [ROWS*DATA_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   frame_done_o,
  output logic                   size_err_o
);

  localparam int AW   = $clog2(MAX_COLS);
  localparam int NL   = ROWS - 1;
  localparam int WL_W = (NL > 1) ? $clog2(NL) : 1;

  state_t                 state, state_nxt;
  logic [COL_W-1:0]       size_q, col, row;
  logic [WL_W-1:0]        wr_line;
  logic                   ready_en;
  logic                   accept, size_ok, col_end, row_end;
  logic                   emit, ram_we, first_beat;
  logic [COL_W-1:0]       cur_size, size_m1;
  logic [DATA_W-1:0]      rd [NL];
  logic [ROWS*DATA_W-1:0] col_data;

  // ready_en keeps the input closed during reset and for one cycle after it
  assign s_axis_tready = ready_en & (~m_axis_tvalid | m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;

  // The size input is only honoured on the first beat; later beats use the latched value
  assign cur_size = (state == IDLE) ? IMG_SIZE_I : size_q;
  assign size_m1  = (cur_size == '0) ? '0 : cur_size - COL_W'(1);
  assign size_ok  = (IMG_SIZE_I >= COL_W'(ROWS)) && (IMG_SIZE_I <= COL_W'(MAX_COLS));
  assign col_end  = (col == size_m1);
  assign row_end  = (row == size_m1);

  for (genvar i = 0; i < NL; i++) begin : g_ram
    line_ram #(.DATA_W(DATA_W), .DEPTH(MAX_COLS)) u_ram (
      .clk   (clk),
      .we    (ram_we && (wr_line == WL_W'(i))),
      .addr  (col[AW-1:0]),
      .wdata (s_axis_tdata),
      .rdata (rd[i])
    );
  end

  // RAM[wr_line] holds the oldest stored row (it is about to be overwritten),
  // so walking forward from wr_line gives oldest-first order.
  always_comb begin
    int k;
    k        = 0;
    col_data = '0;
    for (int j = 0; j < NL; j++) begin
      k = int'(wr_line) + j;
      if (k >= NL) k = k - NL;
      col_data[j*DATA_W +: DATA_W] = rd[k];
`ifdef LINE_BUFFER_ZERO_PAD_EN
      // rows above the image top have not been written in this frame
      if (int'(row) < NL - j) col_data[j*DATA_W +: DATA_W] = '0;
`endif
    end
    col_data[NL*DATA_W +: DATA_W] = s_axis_tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE: begin
          if (!size_ok) state_nxt = (col_end && row_end) ? IDLE : DROP;
          else          state_nxt = FILL;
        end
        FILL:    if (col_end && (row == COL_W'(NL - 1))) state_nxt = RUN;
        RUN:     if (col_end && row_end) state_nxt = IDLE;
        DROP:    if (col_end && row_end) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    emit   = 1'b0;
    ram_we = 1'b0;
    case (state)
      IDLE: begin
        ram_we = accept & size_ok;
`ifdef LINE_BUFFER_ZERO_PAD_EN
        emit   = accept & size_ok;
`endif
      end
      FILL: begin
        ram_we = accept;
`ifdef LINE_BUFFER_ZERO_PAD_EN
        emit   = accept;
`endif
      end
      RUN: begin
        ram_we = accept;
        emit   = accept;
      end
      default: ;
    endcase
`ifdef LINE_BUFFER_ZERO_PAD_EN
    first_beat = (row == '0) && (col == '0);
`else
    first_beat = (row == COL_W'(NL)) && (col == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en      <= 1'b0;
      size_q        <= '0;
      col           <= '0;
      row           <= '0;
      wr_line       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_done_o  <= 1'b0;
      size_err_o    <= 1'b0;
    end else begin
      ready_en     <= 1'b1;
      frame_done_o <= accept && col_end && row_end;

      if (accept && (state == IDLE)) begin
        size_q <= IMG_SIZE_I;
        if (!size_ok) size_err_o <= 1'b1;
      end

      if (accept) begin
        if (col_end) begin
          col <= '0;
          if (row_end) begin
            row     <= '0;
            wr_line <= '0;
          end else begin
            row     <= row + COL_W'(1);
            wr_line <= (wr_line == WL_W'(NL - 1)) ? '0 : wr_line + WL_W'(1);
          end
        end else begin
          col <= col + COL_W'(1);
        end
      end

      // accept only happens when the output slot is free, so the hold case is implicit
      if (emit) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= col_data;
        m_axis_tuser  <= first_beat;
        m_axis_tlast  <= col_end;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/line_buffer_n.md
# line_buffer_n

Parametrised N-row line buffer for sliding-window image kernels. It accepts one pixel per beat on an AXI-Stream slave, stores the previous ROWS-1 image rows in circular line RAMs, and emits a full vertical column of ROWS pixels per accepted beat on an AXI-Stream master. It adds full backpressure, frame framing (tuser/tlast) and optional top zero padding. It sits between the pixel source and the window/kernel stage and generalises the fixed 7-row buffer.

## Interface
- DATA_W, 8, pixel width
- ROWS, 7, window height (≥2)
- MAX_COLS, 512, maximum image side; line RAM depth
- COL_W, $clog2(MAX_COLS)+1, width of size/counters
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- IMG_SIZE_I  in  COL_W  square image side (cols = rows); sampled at frame start only
- s_axis_tdata  in  DATA_W  input pixel
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  ROWS*DATA_W  column; slice [0] oldest row (top), slice [ROWS-1] current pixel
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tuser  out  1  first beat of frame
- m_axis_tlast  out  1  last column of an output row
- frame_done_o  out  1  one-cycle pulse after final input pixel of frame
- size_err_o  out  1  sticky: frame started with illegal size

## Operation
- Accept = s_axis_tvalid & s_axis_tready. s_axis_tready = !m_axis_tvalid | m_axis_tready, forced 0 in reset.
- Counters: col (0..size-1), row (0..size-1), wr_line (0..ROWS-2, circular RAM index).
- On accept: read column `col` of all ROWS-1 RAMs. Reorder them oldest-first using wr_line. Register them with the input pixel into m_axis_tdata. Write the pixel into RAM[wr_line] at `col`. Then advance col. At col==size-1: col←0, row++, wr_line wraps at ROWS-2.
- FSM:
  - IDLE: on first accept, latch IMG_SIZE_I as size. If size<ROWS or size>MAX_COLS, go to DROP and set size_err_o. Otherwise process the beat and go to FILL.
  - FILL: row<ROWS-1. Go to RUN when row reaches ROWS-1.
  - RUN: emit every accepted beat.
  - On the accept of (row=size-1, col=size-1): pulse frame_done_o and return to IDLE with all counters cleared.
  - DROP: accept and discard size*size beats (counters still run), no output; then IDLE.
- Output beat flags:
  - m_axis_tuser=1 on the first emitted beat of the frame.
  - m_axis_tlast=1 when the accepted col==size-1.
- size_err_o is cleared only by rst.
- IMG_SIZE_I changes mid-frame are ignored.
- Reset mid-frame: FSM→IDLE, counters, outputs and flags cleared. RAM contents are not cleared; stale data is never emitted because the row counter gates validity.

## Timing
- Reset values: s_axis_tready 0 (rises 1 cycle after rst release), m_axis_tvalid 0, m_axis_tdata 0, m_axis_tuser 0, m_axis_tlast 0, frame_done_o 0, size_err_o 0.
- Latency: accepted input at edge k → m_axis_tvalid/tdata at edge k (registered, visible in cycle k+1).
- Output is held stable while m_axis_tvalid & !m_axis_tready.
- Throughput: one beat per cycle with m_axis_tready=1.
- Line RAM read is combinational; write is synchronous on accept. The read-before-write value is emitted for the same column.
- frame_done_o is asserted the cycle after the last accept.
- Output beats per frame: (size-ROWS+1)*size.

## Configuration
- LINE_BUFFER_ZERO_PAD_EN defined:
  - Output also emitted in FILL, so there are size*size beats per frame and tuser is on pixel (0,0).
  - Slices for rows not yet written this frame (slice index < ROWS-1-row) are forced to 0.
- LINE_BUFFER_ZERO_PAD_EN undefined: output only in RUN, as above.

## Structure
- Package line_buffer_pkg: FSM state enum (IDLE, FILL, RUN, DROP) and default parameter constants.
- Sub-module line_ram: DATA_W×MAX_COLS, one write port, async read; instantiated ROWS-1 times via generate.

## Test plan
- ROWS=7, size=8, pixel=row*16+col+1, tready=1 → first beat at input (6,0) = {1,17,33,49,65,81,97}, tuser=1. 16 beats total; tlast on cols 7; frame_done_o after pixel (7,7).
- Same stimulus, m_axis_tready toggled 1/0 randomly → identical beat sequence; no loss or duplication; s_axis_tready low exactly when the output is stalled.
- LINE_BUFFER_ZERO_PAD_EN, size=8 → 64 beats. Beat (0,0) = {0,0,0,0,0,0,1}; beat (2,3) = {0,0,0,0,4,20,36}.
- Two back-to-back frames (size 8 then 10, IMG_SIZE_I changed mid-frame 1) → frame 1 uses 8, frame 2 uses 10; no rows from frame 1 appear in frame 2 with pad enabled.
- size=5 (<ROWS) → size_err_o=1, 25 beats accepted, zero output beats, frame_done_o pulses; next size=8 frame is correct.
- rst pulsed at input (4,3) → all outputs 0 immediately; a new size=8 frame gives the scenario-1 results.
